// File: rtl/io_packet_sequencer_pkg.sv
// Shared types and defaults for the IO packet sequencer.
package io_pkg;

  // Width of packet numbers and packet counts.
  localparam int PKT_NUM_W = 16;

  // Width of the receive timeout counter.
  localparam int TIMER_W = 24;

  // Default number of idle cycles in RECV before an ARQ is sent.
  localparam logic [TIMER_W-1:0] TIMEOUT_CYCLES_DEFAULT = 24'd1000000;

  // Default number of consecutive ARQs allowed before the transfer is aborted.
  localparam int MAX_RETRIES_DEFAULT = 4;

  // Sequencer states; the encoding is also exported for debug.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RECV       = 3'd1,
    ST_ARQ        = 3'd2,
    ST_SET_FLAG   = 3'd3,
    ST_RUN        = 3'd4,
    ST_TX         = 3'd5,
    ST_CLEAR_FLAG = 3'd6
  } io_seq_state_t;

  // The timer flags expiry once it has counted down to zero, so it is loaded
  // with one less than the timeout. This makes the ARQ come out exactly
  // TIMEOUT_CYCLES edges after the edge that loaded it.
  function automatic logic [TIMER_W-1:0] timerLoadValue(input logic [TIMER_W-1:0] cycles);
    return (cycles == '0) ? '0 : cycles - 1'b1;
  endfunction

endpackage

// File: rtl/io_packet_sequencer_if.sv
// Handshake and data signals between the sequencer and the RX, MAGIC, memory and TX blocks.
interface io_packet_sequencer_if;
  import io_pkg::*;

  logic                 rx_pkt_done_i;
  logic [PKT_NUM_W-1:0] rx_n_i;
  logic [PKT_NUM_W-1:0] rx_m_i;
  logic                 flag_ready_o;
  logic                 flag_done_clear_o;
  logic                 flag_ack_i;
  logic                 magic_done_i;
  logic                 tx_start_o;
  logic                 tx_done_i;
  logic                 arq_req_o;
  logic [PKT_NUM_W-1:0] arq_n_o;
  logic                 err_o;
  logic [2:0]           state_o;

  // The surrounding system: drives packets, acks and completions.
  modport master (
    output rx_pkt_done_i, rx_n_i, rx_m_i, flag_ack_i, magic_done_i, tx_done_i,
    input  flag_ready_o, flag_done_clear_o, tx_start_o, arq_req_o, arq_n_o, err_o, state_o
  );

  // The sequencer itself.
  modport slave (
    input  rx_pkt_done_i, rx_n_i, rx_m_i, flag_ack_i, magic_done_i, tx_done_i,
    output flag_ready_o, flag_done_clear_o, tx_start_o, arq_req_o, arq_n_o, err_o, state_o
  );

endinterface

// File: rtl/io_packet_sequencer_timer.sv
// Down-counting receive timeout timer that saturates at zero.
module io_timeout_timer
  import io_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [TIMER_W-1:0] load_value,
  output logic               expired
);

  logic [TIMER_W-1:0] r_count;

  // A load always wins; otherwise count down while enabled and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/io_packet_sequencer.sv
// Sequences packet reception with ARQ recovery, then the MAGIC flag, run, transmit and clear handshakes.
module io_packet_sequencer
  import io_pkg::*;
#(
  parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int                 MAX_RETRIES    = MAX_RETRIES_DEFAULT
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  io_packet_sequencer_if.slave  bus
);

  localparam logic [TIMER_W-1:0] TIMER_LOAD  = timerLoadValue(TIMEOUT_CYCLES);
  localparam logic [7:0]         RETRY_LIMIT = 8'(MAX_RETRIES);

  io_seq_state_t        r_state;
  io_seq_state_t        w_nextState;
  logic [PKT_NUM_W-1:0] r_expected;
  logic [PKT_NUM_W-1:0] w_expectedNext;
  logic [PKT_NUM_W-1:0] w_expectedInc;
  logic [PKT_NUM_W-1:0] r_total;
  logic [PKT_NUM_W-1:0] w_totalNext;
  logic [7:0]           r_retryCnt;
  logic [7:0]           w_retryNext;
  logic [7:0]           w_retryInc;
  logic [PKT_NUM_W-1:0] r_arqN;
  logic [PKT_NUM_W-1:0] w_arqNNext;
  logic                 r_arqFromIdle;
  logic                 w_fromIdleNext;
  logic                 w_errNext;
  logic                 w_timerLoad;
  logic                 w_timerEn;
  logic                 w_timerExpired;

  logic                 r_flagReady;
  logic                 r_flagClear;
  logic                 r_txStart;
  logic                 r_arqReq;
  logic                 r_err;

  assign w_expectedInc = r_expected + 1'b1;
  assign w_retryInc    = r_retryCnt + 1'b1;
  assign w_timerEn     = (r_state == ST_RECV);

  io_timeout_timer u_timer (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_n_i),
    .load       (w_timerLoad),
    .en         (w_timerEn),
    .load_value (TIMER_LOAD),
    .expired    (w_timerExpired)
  );

  // Next-state and bookkeeping decisions; a packet is always handled before a timeout.
  always_comb begin
    w_nextState    = r_state;
    w_expectedNext = r_expected;
    w_totalNext    = r_total;
    w_retryNext    = r_retryCnt;
    w_arqNNext     = r_arqN;
    w_fromIdleNext = r_arqFromIdle;
    w_errNext      = 1'b0;
    w_timerLoad    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.rx_pkt_done_i) begin
          if (bus.rx_n_i == '0) begin
            w_totalNext    = bus.rx_m_i;
            w_expectedNext = 16'd1;
            w_retryNext    = '0;
            w_timerLoad    = 1'b1;
            w_nextState    = (bus.rx_m_i <= 16'd1) ? ST_SET_FLAG : ST_RECV;
          end else begin
            w_arqNNext     = '0;
            w_fromIdleNext = 1'b1;
            w_nextState    = ST_ARQ;
          end
        end
      end

      ST_RECV: begin
        if (bus.rx_pkt_done_i) begin
          if (bus.rx_n_i == r_expected) begin
            w_expectedNext = w_expectedInc;
            w_retryNext    = '0;
            w_timerLoad    = 1'b1;
            if (w_expectedInc == r_total) begin
              w_nextState = ST_SET_FLAG;
            end
          end else if (bus.rx_n_i > r_expected) begin
            w_arqNNext     = r_expected;
            w_fromIdleNext = 1'b0;
            w_nextState    = ST_ARQ;
          end
        end else if (w_timerExpired) begin
          w_arqNNext     = r_expected;
          w_fromIdleNext = 1'b0;
          w_nextState    = ST_ARQ;
        end
      end

      ST_ARQ: begin
        w_fromIdleNext = 1'b0;
        if (w_retryInc >= RETRY_LIMIT) begin
          w_retryNext = '0;
          w_errNext   = 1'b1;
          w_nextState = ST_IDLE;
        end else if (r_arqFromIdle) begin
          w_retryNext = w_retryInc;
          w_nextState = ST_IDLE;
        end else begin
          w_retryNext = w_retryInc;
          w_timerLoad = 1'b1;
          w_nextState = ST_RECV;
        end
      end

      ST_SET_FLAG: begin
        if (bus.flag_ack_i) begin
          w_nextState = ST_RUN;
        end
      end

      ST_RUN: begin
        if (bus.magic_done_i) begin
          w_nextState = ST_TX;
        end
      end

      ST_TX: begin
        if (bus.tx_done_i) begin
          w_nextState = ST_CLEAR_FLAG;
        end
      end

      ST_CLEAR_FLAG: begin
        if (bus.flag_ack_i) begin
          w_nextState = ST_IDLE;
        end
      end

      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs are decoded from the next state so they align with it.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state       <= ST_IDLE;
      r_expected    <= '0;
      r_total       <= '0;
      r_retryCnt    <= '0;
      r_arqN        <= '0;
      r_arqFromIdle <= 1'b0;
      r_flagReady   <= 1'b0;
      r_flagClear   <= 1'b0;
      r_txStart     <= 1'b0;
      r_arqReq      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_expected    <= w_expectedNext;
      r_total       <= w_totalNext;
      r_retryCnt    <= w_retryNext;
      r_arqN        <= w_arqNNext;
      r_arqFromIdle <= w_fromIdleNext;
      r_flagReady   <= (w_nextState == ST_SET_FLAG);
      r_flagClear   <= (w_nextState == ST_CLEAR_FLAG);
      r_txStart     <= (w_nextState == ST_TX) && (r_state != ST_TX);
      r_arqReq      <= (w_nextState == ST_ARQ);
      r_err         <= w_errNext;
    end
  end

  assign bus.flag_ready_o      = r_flagReady;
  assign bus.flag_done_clear_o = r_flagClear;
  assign bus.tx_start_o        = r_txStart;
  assign bus.arq_req_o         = r_arqReq;
  assign bus.arq_n_o           = r_arqN;
  assign bus.err_o             = r_err;
  assign bus.state_o           = r_state;

endmodule

// File: tb/tb_io_packet_sequencer.sv
// Directed bench for io_packet_sequencer with a short timeout and two retries.
module tb_io_packet_sequencer;
  import io_pkg::*;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   failCount;

  io_packet_sequencer_if bus ();

  io_packet_sequencer #(
    .TIMEOUT_CYCLES (24'd16),
    .MAX_RETRIES    (2)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case anything below stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One-cycle RX packet pulse; returns just after the edge that sampled it.
  task automatic applyStimulus(input logic [15:0] n, input logic [15:0] m);
    bus.rx_n_i        = n;
    bus.rx_m_i        = m;
    bus.rx_pkt_done_i = 1'b1;
    tick();
    bus.rx_pkt_done_i = 1'b0;
  endtask

  // Walks from SET_FLAG through RUN, TX and CLEAR_FLAG back to IDLE.
  task automatic finishTransfer(input string tag);
    bus.flag_ack_i = 1'b1;
    tick();
    bus.flag_ack_i   = 1'b0;
    bus.magic_done_i = 1'b1;
    tick();
    bus.magic_done_i = 1'b0;
    tick();
    bus.tx_done_i = 1'b1;
    tick();
    bus.tx_done_i  = 1'b0;
    bus.flag_ack_i = 1'b1;
    tick();
    bus.flag_ack_i = 1'b0;
    checkOutput(tag, 32'(bus.state_o), 32'd0);
  endtask

  initial begin
    int edgeIdx;
    checkCount = 0;
    failCount  = 0;
    rst_n             = 1'b0;
    bus.rx_pkt_done_i = 1'b0;
    bus.rx_n_i        = '0;
    bus.rx_m_i        = '0;
    bus.flag_ack_i    = 1'b0;
    bus.magic_done_i  = 1'b0;
    bus.tx_done_i     = 1'b0;

    // Reset values
    tick();
    tick();
    checkOutput("rst_state", 32'(bus.state_o), 32'd0);
    checkOutput("rst_flag_ready", 32'(bus.flag_ready_o), 32'd0);
    checkOutput("rst_arq_n", 32'(bus.arq_n_o), 32'd0);
    checkOutput("rst_arq_req", 32'(bus.arq_req_o), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("rel_arq_req", 32'(bus.arq_req_o), 32'd0);
    checkOutput("rel_err", 32'(bus.err_o), 32'd0);
    checkOutput("rel_tx_start", 32'(bus.tx_start_o), 32'd0);
    checkOutput("rel_clear", 32'(bus.flag_done_clear_o), 32'd0);

    // Complete in-order transfer, M=3
    applyStimulus(16'd0, 16'd3);
    checkOutput("a_recv0", 32'(bus.state_o), 32'd1);
    applyStimulus(16'd1, 16'd3);
    checkOutput("a_recv1", 32'(bus.state_o), 32'd1);
    applyStimulus(16'd2, 16'd3);
    checkOutput("a_setflag", 32'(bus.state_o), 32'd3);
    checkOutput("a_flag_ready", 32'(bus.flag_ready_o), 32'd1);
    tick();
    checkOutput("a_flag_hold", 32'(bus.flag_ready_o), 32'd1);
    bus.flag_ack_i = 1'b1;
    tick();
    bus.flag_ack_i = 1'b0;
    checkOutput("a_run", 32'(bus.state_o), 32'd4);
    checkOutput("a_flag_drop", 32'(bus.flag_ready_o), 32'd0);
    tick();
    checkOutput("a_run_wait", 32'(bus.state_o), 32'd4);
    bus.magic_done_i = 1'b1;
    tick();
    bus.magic_done_i = 1'b0;
    checkOutput("a_tx", 32'(bus.state_o), 32'd5);
    checkOutput("a_tx_start", 32'(bus.tx_start_o), 32'd1);
    tick();
    checkOutput("a_tx_start_once", 32'(bus.tx_start_o), 32'd0);
    checkOutput("a_tx_wait", 32'(bus.state_o), 32'd5);
    bus.tx_done_i = 1'b1;
    tick();
    bus.tx_done_i = 1'b0;
    checkOutput("a_clear", 32'(bus.state_o), 32'd6);
    checkOutput("a_clear_out", 32'(bus.flag_done_clear_o), 32'd1);
    checkOutput("a_clear_excl", 32'(bus.flag_ready_o), 32'd0);
    applyStimulus(16'd0, 16'd3);
    checkOutput("a_pkt_ignored", 32'(bus.state_o), 32'd6);
    checkOutput("a_clear_hold", 32'(bus.flag_done_clear_o), 32'd1);
    bus.flag_ack_i = 1'b1;
    tick();
    bus.flag_ack_i = 1'b0;
    checkOutput("a_idle", 32'(bus.state_o), 32'd0);
    checkOutput("a_clear_drop", 32'(bus.flag_done_clear_o), 32'd0);

    // Duplicate without reload, timeout after 16 cycles, then abort after two ARQs
    applyStimulus(16'd0, 16'd3);
    repeat (5) tick();
    applyStimulus(16'd0, 16'd3);
    checkOutput("c_dup_state", 32'(bus.state_o), 32'd1);
    checkOutput("c_dup_no_arq", 32'(bus.arq_req_o), 32'd0);
    edgeIdx = 0;
    for (int k = 7; k <= 40; k++) begin
      tick();
      if (bus.arq_req_o) begin
        edgeIdx = k;
        break;
      end
    end
    checkOutput("c_timeout_edge", 32'(edgeIdx), 32'd16);
    checkOutput("c_arq_n1", 32'(bus.arq_n_o), 32'd1);
    edgeIdx = 0;
    for (int k = 17; k <= 60; k++) begin
      tick();
      if (bus.arq_req_o) begin
        edgeIdx = k;
        break;
      end
    end
    checkOutput("c_retry_edge", 32'(edgeIdx), 32'd33);
    checkOutput("c_arq_n2", 32'(bus.arq_n_o), 32'd1);
    tick();
    checkOutput("c_err", 32'(bus.err_o), 32'd1);
    checkOutput("c_err_idle", 32'(bus.state_o), 32'd0);
    tick();
    checkOutput("c_err_pulse", 32'(bus.err_o), 32'd0);

    // Non-zero packet while idle
    applyStimulus(16'd5, 16'd3);
    checkOutput("e_arq_state", 32'(bus.state_o), 32'd2);
    checkOutput("e_arq_req", 32'(bus.arq_req_o), 32'd1);
    checkOutput("e_arq_n", 32'(bus.arq_n_o), 32'd0);
    tick();
    checkOutput("e_back_idle", 32'(bus.state_o), 32'd0);
    checkOutput("e_arq_drop", 32'(bus.arq_req_o), 32'd0);
    checkOutput("e_no_err", 32'(bus.err_o), 32'd0);

    // An accepted packet clears the retry count, M=4
    applyStimulus(16'd0, 16'd4);
    applyStimulus(16'd3, 16'd4);
    checkOutput("d_arq1_n", 32'(bus.arq_n_o), 32'd1);
    tick();
    checkOutput("d_recv1", 32'(bus.state_o), 32'd1);
    applyStimulus(16'd1, 16'd4);
    applyStimulus(16'd3, 16'd4);
    checkOutput("d_arq2_req", 32'(bus.arq_req_o), 32'd1);
    checkOutput("d_arq2_n", 32'(bus.arq_n_o), 32'd2);
    tick();
    checkOutput("d_recv2", 32'(bus.state_o), 32'd1);
    checkOutput("d_no_err", 32'(bus.err_o), 32'd0);
    applyStimulus(16'd2, 16'd4);
    applyStimulus(16'd3, 16'd4);
    checkOutput("d_setflag", 32'(bus.state_o), 32'd3);
    finishTransfer("d_done");

    // M=1 goes straight to SET_FLAG; reset there acts without a clock edge
    applyStimulus(16'd0, 16'd1);
    checkOutput("m1_setflag", 32'(bus.state_o), 32'd3);
    checkOutput("m1_flag_ready", 32'(bus.flag_ready_o), 32'd1);
    rst_n = 1'b0;
    #2;
    checkOutput("async_state", 32'(bus.state_o), 32'd0);
    checkOutput("async_flag", 32'(bus.flag_ready_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("async_rel_state", 32'(bus.state_o), 32'd0);
    checkOutput("async_rel_flag", 32'(bus.flag_ready_o), 32'd0);

    // Gap recovery, M=3: n=0, n=2 -> ARQ for 1, resend 1 and 2
    applyStimulus(16'd0, 16'd3);
    applyStimulus(16'd2, 16'd3);
    checkOutput("b_arq_req", 32'(bus.arq_req_o), 32'd1);
    checkOutput("b_arq_n", 32'(bus.arq_n_o), 32'd1);
    tick();
    checkOutput("b_recv", 32'(bus.state_o), 32'd1);
    checkOutput("b_arq_pulse", 32'(bus.arq_req_o), 32'd0);
    checkOutput("b_arq_n_hold", 32'(bus.arq_n_o), 32'd1);
    applyStimulus(16'd1, 16'd3);
    checkOutput("b_recv1", 32'(bus.state_o), 32'd1);
    applyStimulus(16'd2, 16'd3);
    checkOutput("b_setflag", 32'(bus.state_o), 32'd3);
    finishTransfer("b_done");

    // Packet arriving in the same cycle as expiry wins
    applyStimulus(16'd0, 16'd3);
    repeat (15) tick();
    applyStimulus(16'd1, 16'd3);
    checkOutput("f_no_arq", 32'(bus.arq_req_o), 32'd0);
    checkOutput("f_recv", 32'(bus.state_o), 32'd1);
    applyStimulus(16'd2, 16'd3);
    checkOutput("f_setflag", 32'(bus.state_o), 32'd3);
    finishTransfer("f_done");

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule
